// File: rtl/toeplitz_shift_sched_pkg.sv
// toeplitz_shift_sched_pkg
// Shared definitions for the Toeplitz seed-shifter scheduler:
//   - sched_state_e : scheduler FSM state encoding
//   - *_DEF         : default timing / geometry constants of the shifter
//   - N_CH          : number of hash channels sharing the shifter
//   - PHASE_W       : width of the shared lead/gap/tail/ack phase counter
//   - ch_onehot()   : channel index to one-hot done vector
package toeplitz_shift_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LEAD = 3'd2,
    ST_ROW  = 3'd3,
    ST_GAP  = 3'd4,
    ST_TAIL = 3'd5,
    ST_DONE = 3'd6
  } sched_state_e;

  localparam int ROUNDS_DEF      = 128;
  localparam int SHIFTS_DEF      = 32;
  localparam int LEAD_DEF        = 3;
  localparam int GAP_DEF         = 3;
  localparam int TAIL_DEF        = 2;
  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int AW_DEF          = 12;

  localparam int N_CH    = 2;
  // Lead, gap, tail and ack-wait lengths must all fit in this counter.
  localparam int PHASE_W = 8;

  function automatic logic [N_CH-1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/toeplitz_shift_sched_rr_arb2.sv
// toeplitz_shift_sched_rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from req and
// the priority pointer; the pointer moves to the channel opposite adv_ch on
// an advance strobe (job completion).
// Ports:
//   clk_in      in  clock, rising edge
//   rst         in  synchronous active-high reset (pointer -> channel 0)
//   req         in  per-channel request
//   advance     in  1-cycle strobe: a job for adv_ch has finished
//   adv_ch      in  channel that just finished
//   grant_valid out at least one channel requests
//   grant_ch    out channel that wins this cycle
module toeplitz_shift_sched_rr_arb2
  import toeplitz_shift_sched_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  input  logic            adv_ch,
  output logic            grant_valid,
  output logic            grant_ch
);

  logic ptr_r;

  // Grant selection: the pointer only matters when both channels request.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_ch = ptr_r;
    end else if (req[1]) begin
      grant_ch = 1'b1;
    end else begin
      grant_ch = 1'b0;
    end
  end

  // Priority pointer: favour the other channel after each completed job.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= ~adv_ch;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/toeplitz_shift_sched.sv
// toeplitz_shift_sched
// Shares one Toeplitz seed shifter between two hash channels. Grants a
// channel round-robin, starts the shifter (shift_en until seed_ack), then
// follows the shifter's fixed row timing to strobe row_valid, step key_addr
// and signal completion on done. An unanswered start raises err_timeout.
// Ports:
//   clk_in      in  clock, rising edge
//   rst         in  synchronous active-high reset
//   req[1:0]    in  per-channel job request (level)
//   seed_sel    out granted channel, stable while busy
//   shift_en    out start request to the shifter (drops on seed_ack)
//   seed_ack    in  shifter latched the seed (1-cycle pulse)
//   acc_clr     out 1-cycle accumulator clear, first cycle after grant
//   row_valid   out current shifter row is valid
//   key_addr    out raw-key bit index of the current row
//   done[1:0]   out 1-cycle one-hot completion pulse
//   busy        out job in progress
//   err_timeout out sticky ack-timeout flag
// LEAD must be >= 2; GAP, TAIL, ACK_TIMEOUT must be >= 1.
module toeplitz_shift_sched
  import toeplitz_shift_sched_pkg::*;
#(
  parameter int ROUNDS      = ROUNDS_DEF,
  parameter int SHIFTS      = SHIFTS_DEF,
  parameter int LEAD        = LEAD_DEF,
  parameter int GAP         = GAP_DEF,
  parameter int TAIL        = TAIL_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int AW          = AW_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic            seed_sel,
  output logic            shift_en,
  input  logic            seed_ack,
  output logic            acc_clr,
  output logic            row_valid,
  output logic [AW-1:0]   key_addr,
  output logic [N_CH-1:0] done,
  output logic            busy,
  output logic            err_timeout
);

  localparam int SW = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  // LEAD state lasts LEAD-1 cycles so the first row lands LEAD cycles
  // after the cycle in which seed_ack is seen.
  localparam logic [PHASE_W-1:0] LEAD_LAST = PHASE_W'(LEAD - 2);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP - 1);
  localparam logic [PHASE_W-1:0] TAIL_LAST = PHASE_W'(TAIL - 1);
  localparam logic [PHASE_W-1:0] ACK_LAST  = PHASE_W'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0]      ROW_LAST  = SW'(SHIFTS - 1);
  localparam logic [RW-1:0]      RND_LAST  = RW'(ROUNDS - 1);

  sched_state_e         state_r, state_nx_s;
  logic [PHASE_W-1:0]   phase_r, phase_nx_s;
  logic [SW-1:0]        row_r, row_nx_s;
  logic [RW-1:0]        round_r, round_nx_s;
  logic [AW-1:0]        key_r, key_nx_s;
  logic                 seed_sel_r, seed_sel_nx_s;
  logic                 acc_clr_r, acc_clr_nx_s;
  logic                 err_r, err_nx_s;
  logic                 shift_en_s;
  logic [N_CH-1:0]      done_s;
  logic                 advance_s;
  logic                 grant_valid_s;
  logic                 grant_ch_s;

  toeplitz_shift_sched_rr_arb2 u_arb (
    .clk_in      (clk_in),
    .rst         (rst),
    .req         (req),
    .advance     (advance_s),
    .adv_ch      (seed_sel_r),
    .grant_valid (grant_valid_s),
    .grant_ch    (grant_ch_s)
  );

  // Next-state, counter and output decode for the scheduler FSM.
  always_comb begin
    state_nx_s    = state_r;
    phase_nx_s    = phase_r;
    row_nx_s      = row_r;
    round_nx_s    = round_r;
    key_nx_s      = key_r;
    seed_sel_nx_s = seed_sel_r;
    acc_clr_nx_s  = 1'b0;
    err_nx_s      = err_r;
    shift_en_s    = 1'b0;
    done_s        = 2'b00;
    advance_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        phase_nx_s = '0;
        row_nx_s   = '0;
        round_nx_s = '0;
        key_nx_s   = '0;
        if (grant_valid_s) begin
          seed_sel_nx_s = grant_ch_s;
          acc_clr_nx_s  = 1'b1;
          state_nx_s    = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // shift_en drops combinationally in the ack cycle so the shifter
        // never sees a second start.
        if (seed_ack) begin
          shift_en_s = 1'b0;
          phase_nx_s = '0;
          state_nx_s = ST_LEAD;
        end else if (phase_r == ACK_LAST) begin
          // Give up: finish through DONE so done pulses and the pointer moves.
          shift_en_s = 1'b1;
          err_nx_s   = 1'b1;
          phase_nx_s = '0;
          state_nx_s = ST_DONE;
        end else begin
          shift_en_s = 1'b1;
          phase_nx_s = phase_r + PHASE_W'(1);
        end
      end

      ST_LEAD: begin
        if (phase_r == LEAD_LAST) begin
          phase_nx_s = '0;
          state_nx_s = ST_ROW;
        end else begin
          phase_nx_s = phase_r + PHASE_W'(1);
        end
      end

      ST_ROW: begin
        if (row_r == ROW_LAST) begin
          row_nx_s = '0;
          if (round_r == RND_LAST) begin
            // Last row of the job: key_addr stays at its final index.
            phase_nx_s = '0;
            state_nx_s = ST_TAIL;
          end else begin
            round_nx_s = round_r + RW'(1);
            key_nx_s   = key_r + AW'(1);
            phase_nx_s = '0;
            state_nx_s = ST_GAP;
          end
        end else begin
          row_nx_s = row_r + SW'(1);
          key_nx_s = key_r + AW'(1);
        end
      end

      ST_GAP: begin
        if (phase_r == GAP_LAST) begin
          phase_nx_s = '0;
          state_nx_s = ST_ROW;
        end else begin
          phase_nx_s = phase_r + PHASE_W'(1);
        end
      end

      ST_TAIL: begin
        if (phase_r == TAIL_LAST) begin
          phase_nx_s = '0;
          state_nx_s = ST_DONE;
        end else begin
          phase_nx_s = phase_r + PHASE_W'(1);
        end
      end

      ST_DONE: begin
        done_s     = ch_onehot(seed_sel_r);
        advance_s  = 1'b1;
        key_nx_s   = '0;
        phase_nx_s = '0;
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      phase_r    <= '0;
      row_r      <= '0;
      round_r    <= '0;
      key_r      <= '0;
      seed_sel_r <= 1'b0;
      acc_clr_r  <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      phase_r    <= phase_nx_s;
      row_r      <= row_nx_s;
      round_r    <= round_nx_s;
      key_r      <= key_nx_s;
      seed_sel_r <= seed_sel_nx_s;
      acc_clr_r  <= acc_clr_nx_s;
      err_r      <= err_nx_s;
    end
  end

  assign seed_sel    = seed_sel_r;
  assign shift_en    = shift_en_s;
  assign acc_clr     = acc_clr_r;
  assign row_valid   = (state_r == ST_ROW);
  assign key_addr    = key_r;
  assign done        = done_s;
  assign busy        = (state_r != ST_IDLE);
  assign err_timeout = err_r;

endmodule

// File: tb/tb_toeplitz_shift_sched.sv
// Directed bench for toeplitz_shift_sched: a small instance (ROUNDS=2,
// SHIFTS=4) for detailed timing and a default instance for a full job.
module tb_toeplitz_shift_sched;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst;
  logic [1:0]  s_req, d_req;
  logic        s_ack, d_ack;
  logic        s_seed_sel, s_shift_en, s_acc_clr, s_row_valid, s_busy, s_err;
  logic [11:0] s_key_addr;
  logic [1:0]  s_done;
  logic        d_seed_sel, d_shift_en, d_acc_clr, d_row_valid, d_busy, d_err;
  logic [11:0] d_key_addr;
  logic [1:0]  d_done;
  logic [19:0] s_all;

  assign s_all = {s_seed_sel, s_shift_en, s_acc_clr, s_row_valid, s_key_addr,
                  s_done, s_busy, s_err};

  int total = 0;
  int bad   = 0;

  // Expected per-cycle behaviour of the small instance from the first row on.
  int rv_tab   [15] = '{1,1,1,1, 0,0,0, 1,1,1,1, 0,0, 0, 0};
  int key_tab  [15] = '{0,1,2,3, 4,4,4, 4,5,6,7, 7,7, 7, 0};
  int done_tab [15] = '{0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 1, 0};
  int busy_tab [15] = '{1,1,1,1, 1,1,1, 1,1,1,1, 1,1, 1, 0};

  toeplitz_shift_sched #(
    .ROUNDS(2), .SHIFTS(4), .LEAD(3), .GAP(3), .TAIL(2), .ACK_TIMEOUT(15), .AW(12)
  ) dut_s (
    .clk_in(clk_in), .rst(rst), .req(s_req), .seed_sel(s_seed_sel),
    .shift_en(s_shift_en), .seed_ack(s_ack), .acc_clr(s_acc_clr),
    .row_valid(s_row_valid), .key_addr(s_key_addr), .done(s_done),
    .busy(s_busy), .err_timeout(s_err)
  );

  toeplitz_shift_sched dut_d (
    .clk_in(clk_in), .rst(rst), .req(d_req), .seed_sel(d_seed_sel),
    .shift_en(d_shift_en), .seed_ack(d_ack), .acc_clr(d_acc_clr),
    .row_valid(d_row_valid), .key_addr(d_key_addr), .done(d_done),
    .busy(d_busy), .err_timeout(d_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Run one small-instance job: wait for shift_en, ack at once, wait for done.
  task automatic run_job(input string tag, input logic exp_ch, input bit drop);
    int   n;
    logic sel;
    bit   stable;
    n = 0;
    while (s_shift_en !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(s_shift_en), 32'd1);
    sel = s_seed_sel;
    chk({tag, "_sel"}, 32'(s_seed_sel), 32'(exp_ch));
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    stable = 1'b1;
    n = 0;
    while (s_done === 2'b00 && n < 60) begin
      if (s_seed_sel !== sel) stable = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(s_done), exp_ch ? 32'd2 : 32'd1);
    chk({tag, "_sel_stable"}, 32'(stable), 32'd1);
    if (drop) s_req = 2'b00;
    tick();
  endtask

  initial begin
    int n;
    int cyc, rows, last_key, key_err, shen, gap_bad, gaps, zrun, first_row;
    int burst, burst_bad;

    rst = 1'b1; s_req = 2'b00; d_req = 2'b00; s_ack = 1'b0; d_ack = 1'b0;
    tick();
    tick();
    chk("reset_outs", 32'(s_all), 32'd0);
    chk("reset_d_busy", 32'(d_busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(s_busy), 32'd0);

    // ---- single job on channel 0 ----
    s_req = 2'b01;
    chk("no_same_cycle_grant", 32'(s_busy), 32'd0);
    tick();
    chk("t1_acc_clr", 32'(s_acc_clr), 32'd1);
    chk("t1_sel", 32'(s_seed_sel), 32'd0);
    chk("t1_shift_en", 32'(s_shift_en), 32'd1);
    tick();
    chk("t1_acc_clr_once", 32'(s_acc_clr), 32'd0);
    chk("t1_shift_en_hold", 32'(s_shift_en), 32'd1);
    s_ack = 1'b1;
    #1;
    chk("t1_shift_en_drop", 32'(s_shift_en), 32'd0);
    tick();
    s_ack = 1'b0;
    chk("t1_lead1_rv", 32'(s_row_valid), 32'd0);
    tick();
    chk("t1_lead2_rv", 32'(s_row_valid), 32'd0);
    tick();
    for (int i = 0; i < 15; i++) begin
      s_ack = (i == 1) ? 1'b1 : 1'b0;   // spurious ack while in ROW
      if (i == 5) s_req = 2'b00;         // request dropped mid-job
      chk("t1_rv", 32'(s_row_valid), 32'(rv_tab[i]));
      chk("t1_key", 32'(s_key_addr), 32'(key_tab[i]));
      chk("t1_done", 32'(s_done), 32'(done_tab[i]));
      chk("t1_busy", 32'(s_busy), 32'(busy_tab[i]));
      chk("t1_no_shift_en", 32'(s_shift_en), 32'd0);
      chk("t1_no_acc_clr", 32'(s_acc_clr), 32'd0);
      tick();
    end
    s_ack = 1'b0;
    chk("t1_idle_after", 32'(s_busy), 32'd0);
    chk("t1_no_err", 32'(s_err), 32'd0);

    // ---- spurious ack in IDLE ----
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("spur_idle_busy", 32'(s_busy), 32'd0);
    tick();
    chk("spur_idle_busy2", 32'(s_busy), 32'd0);

    // ---- ack timeout on channel 1 ----
    s_req = 2'b10;
    tick();
    chk("to_sel", 32'(s_seed_sel), 32'd1);
    for (int k = 0; k < 15; k++) begin
      chk("to_shift_en_hi", 32'(s_shift_en), 32'd1);
      chk("to_no_rv", 32'(s_row_valid), 32'd0);
      tick();
    end
    chk("to_shift_en_drop", 32'(s_shift_en), 32'd0);
    chk("to_done", 32'(s_done), 32'd2);
    chk("to_err", 32'(s_err), 32'd1);
    s_req = 2'b00;
    tick();
    chk("to_err_sticky", 32'(s_err), 32'd1);
    chk("to_idle", 32'(s_busy), 32'd0);
    chk("to_done_clear", 32'(s_done), 32'd0);

    // ---- contention: both request, grants alternate 0,1,0 ----
    s_req = 2'b11;
    run_job("rr0", 1'b0, 1'b0);
    run_job("rr1", 1'b1, 1'b0);
    run_job("rr2", 1'b0, 1'b1);
    chk("rr_idle", 32'(s_busy), 32'd0);
    tick();
    chk("rr_idle2", 32'(s_busy), 32'd0);

    // ---- reset mid-ROW ----
    s_req = 2'b01;
    n = 0;
    while (s_shift_en !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    n = 0;
    while (!(s_row_valid === 1'b1 && s_key_addr === 12'd5) && n < 30) begin
      tick();
      n++;
    end
    chk("mid_key5", 32'(s_key_addr), 32'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", 32'(s_all), 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_busy", 32'(s_busy), 32'd1);
    chk("restart_acc_clr", 32'(s_acc_clr), 32'd1);
    chk("restart_key0", 32'(s_key_addr), 32'd0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    tick();
    tick();
    chk("restart_first_rv", 32'(s_row_valid), 32'd1);
    chk("restart_first_key", 32'(s_key_addr), 32'd0);
    n = 0;
    while (s_done === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("restart_done", 32'(s_done), 32'd1);
    s_req = 2'b00;
    tick();
    chk("restart_idle", 32'(s_busy), 32'd0);

    // ---- default parameters, one full job ----
    d_req = 2'b01;
    tick();
    chk("d_acc_clr", 32'(d_acc_clr), 32'd1);
    chk("d_shift_en", 32'(d_shift_en), 32'd1);
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    cyc = 1; rows = 0; last_key = -1; key_err = 0; shen = 0; gap_bad = 0;
    gaps = 0; zrun = 0; first_row = 0; burst = 0; burst_bad = 0;
    while (d_done === 2'b00 && cyc < 6000) begin
      if (d_shift_en === 1'b1) shen++;
      if (d_row_valid === 1'b1) begin
        if (rows == 0) first_row = cyc;
        if (rows > 0 && zrun != 0) begin
          gaps++;
          if (zrun != 3) gap_bad++;
        end
        if (d_key_addr !== 12'(rows)) key_err++;
        last_key = int'(d_key_addr);
        rows++;
        zrun = 0;
        burst++;
      end else begin
        if (burst != 0 && burst != 32) burst_bad++;
        burst = 0;
        if (rows > 0) zrun++;
      end
      tick();
      cyc++;
    end
    chk("d_done", 32'(d_done), 32'd1);
    chk("d_rows", 32'(rows), 32'd4096);
    chk("d_last_key", 32'(last_key), 32'd4095);
    chk("d_key_seq_err", 32'(key_err), 32'd0);
    chk("d_first_row_lat", 32'(first_row), 32'd3);
    chk("d_gaps", 32'(gaps), 32'd127);
    chk("d_gap_len_bad", 32'(gap_bad), 32'd0);
    chk("d_burst_len_bad", 32'(burst_bad), 32'd0);
    chk("d_shift_en_after_ack", 32'(shen), 32'd0);
    chk("d_tail_len", 32'(zrun), 32'd2);
    d_req = 2'b00;
    tick();
    chk("d_idle", 32'(d_busy), 32'd0);
    chk("d_no_err", 32'(d_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
